imm_gen: RTL and testbench

IMM_GEN -- requirements
Module: imm_gen

---
 rtl/imm_gen_pkg.sv | 45 ++++
 rtl/imm_gen_if.sv | 29 ++
 rtl/imm_decode.sv | 43 ++++
 rtl/imm_gen.sv | 46 ++++
 tb/tb_imm_gen.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/imm_gen_pkg.sv
// ============================================================================
// imm_gen_pkg : RV64I opcode constants and immediate-format encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package imm_gen_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

  // Case equality means X/Z opcode bits never match a listed opcode.
  function automatic imm_fmt_e opcode_fmt(input logic [6:0] op);
    imm_fmt_e fmt;
    case (op)
      OP_IMM, OP_IMM_32, OP_LOAD, OP_JALR, OP_SYSTEM: fmt = FMT_I;
      OP_STORE:                                       fmt = FMT_S;
      OP_BRANCH:                                      fmt = FMT_B;
      OP_LUI, OP_AUIPC:                               fmt = FMT_U;
      OP_JAL:                                         fmt = FMT_J;
      default:                                        fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imm_gen_if.sv
// ============================================================================
// imm_gen_if : instruction-in / immediate-out bus for the immediate generator
// Rev 1.0
// ============================================================================
`default_nettype none

interface imm_gen_if #(
  parameter int XLEN = 64
) ();

  logic [31:0]           inst_in;
  logic [XLEN-1:0]       inst_out;
  imm_gen_pkg::imm_fmt_e imm_fmt;

  modport master (
    output inst_in,
    input  inst_out,
    input  imm_fmt
  );

  modport slave (
    input  inst_in,
    output inst_out,
    output imm_fmt
  );

endinterface

`default_nettype wire

// File: rtl/imm_decode.sv
// ============================================================================
// imm_decode : combinational RV64I immediate extraction and format decode
// Rev 1.0
// ============================================================================
`default_nettype none

module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o
);

  logic            sign;
  imm_fmt_e        fmt;
  logic [XLEN-1:0] imm;

  assign sign = inst_i[31];

  always_comb begin
    fmt = opcode_fmt(inst_i[6:0]);
    imm = '0;
    case (fmt)
      FMT_I: imm = {{(XLEN-12){sign}}, inst_i[31:20]};
      FMT_S: imm = {{(XLEN-12){sign}}, inst_i[31:25], inst_i[11:7]};
      FMT_B: imm = {{(XLEN-13){sign}}, inst_i[31], inst_i[7],
                    inst_i[30:25], inst_i[11:8], 1'b0};
      FMT_U: imm = {{(XLEN-32){sign}}, inst_i[31:12], 12'b0};
      FMT_J: imm = {{(XLEN-21){sign}}, inst_i[31], inst_i[19:12],
                    inst_i[20], inst_i[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign imm_o = imm;
  assign fmt_o = fmt;

endmodule

`default_nettype wire

// File: rtl/imm_gen.sv
// ============================================================================
// imm_gen : one-cycle registered RV64I immediate generator
// Rev 1.0
// ============================================================================
`default_nettype none

module imm_gen
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic        clk,
  input  logic        reset,
  imm_gen_if.slave    bus
);

  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] imm_q;
  imm_fmt_e        fmt_d;
  imm_fmt_e        fmt_q;

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .inst_i (bus.inst_in),
    .imm_o  (imm_d),
    .fmt_o  (fmt_d)
  );

  // Active-low reset clears the outputs immediately, independent of clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imm_q <= '0;
      fmt_q <= FMT_NONE;
    end else begin
      imm_q <= imm_d;
      fmt_q <= fmt_d;
    end
  end

  assign bus.inst_out = imm_q;
  assign bus.imm_fmt  = fmt_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_gen.sv
// ============================================================================
// tb_imm_gen : self-checking bench for imm_gen against an arithmetic model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_imm_gen;
  import imm_gen_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  imm_gen_if #(.XLEN(64)) bus ();

  imm_gen #(.XLEN(64)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  // Reference model: immediates as signed integers built from weighted fields.
  function automatic void ref_model(input logic [31:0] w, output logic [63:0] imm,
                                    output logic [2:0] fmt);
    longint v;
    v   = 0;
    fmt = 3'd0;
    case (w[6:0])
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        fmt = 3'd1;
        v   = longint'(w[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'b0100011: begin
        fmt = 3'd2;
        v   = longint'(w[31:25]) * 32 + longint'(w[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'b1100011: begin
        fmt = 3'd3;
        v   = longint'(w[31]) * 4096 + longint'(w[7]) * 2048
            + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
        if (w[31]) v -= 8192;
      end
      7'b0110111, 7'b0010111: begin
        fmt = 3'd4;
        v   = longint'(w[31:12]) * 4096;
        if (w[31]) v -= 64'sh1_0000_0000;
      end
      7'b1101111: begin
        fmt = 3'd5;
        v   = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096
            + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
        if (w[31]) v -= 2097152;
      end
      default: begin
        fmt = 3'd0;
        v   = 0;
      end
    endcase
    imm = v;
  endfunction

  task automatic test_reset();
    reset       = 1'b0;
    bus.inst_in = 32'h800000B7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.inst_out !== 64'h0) begin
      errors++;
      $display("FAIL reset_imm: got %h expected %h", bus.inst_out, 64'h0);
    end
    checks++;
    if (bus.imm_fmt !== FMT_NONE) begin
      errors++;
      $display("FAIL reset_fmt: got %0d expected 0", bus.imm_fmt);
    end
    // First capture must happen on the first rising edge with reset high.
    reset       = 1'b1;
    bus.inst_in = 32'h06410093;
    @(negedge clk);
    checks++;
    if (bus.inst_out !== 64'h64 || bus.imm_fmt !== FMT_I) begin
      errors++;
      $display("FAIL reset_release: got %h/%0d expected %h/1",
               bus.inst_out, bus.imm_fmt, 64'h64);
    end
  endtask

  task automatic test_directed();
    logic [31:0] insts [10] = '{32'h06410093, 32'h3E112423, 32'hBE112423,
                                32'h09612083, 32'h89612083, 32'h00208563,
                                32'h80208563, 32'h800000B7, 32'h0000006F,
                                32'hFFFFFFB3};
    logic [63:0] imms [10]  = '{64'h0000000000000064, 64'h00000000000003E8,
                                64'hFFFFFFFFFFFFFBE8, 64'h0000000000000096,
                                64'hFFFFFFFFFFFFF896, 64'h000000000000000A,
                                64'hFFFFFFFFFFFFF00A, 64'hFFFFFFFF80000000,
                                64'h0000000000000000, 64'h0000000000000000};
    logic [2:0]  fmts [10]  = '{3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd3, 3'd3,
                                3'd4, 3'd5, 3'd0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.inst_in = insts[i];
      @(negedge clk);
      checks++;
      if (bus.inst_out !== imms[i]) begin
        errors++;
        $display("FAIL directed_imm[%0d] inst=%h: got %h expected %h",
                 i, insts[i], bus.inst_out, imms[i]);
      end
      checks++;
      if (bus.imm_fmt !== fmts[i]) begin
        errors++;
        $display("FAIL directed_fmt[%0d] inst=%h: got %0d expected %0d",
                 i, insts[i], bus.imm_fmt, fmts[i]);
      end
    end
  endtask

  task automatic test_back_to_back_random();
    logic [6:0]  ops [10] = '{7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111,
                              7'b1110011, 7'b0100011, 7'b1100011, 7'b0110111,
                              7'b0010111, 7'b1101111};
    logic [31:0] r;
    logic [31:0] w;
    logic [6:0]  op;
    logic [63:0] exp_imm;
    logic [2:0]  exp_fmt;
    bit          have_prev;
    have_prev = 1'b0;
    exp_imm   = '0;
    exp_fmt   = '0;
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      if (have_prev) begin
        checks++;
        if (bus.inst_out !== exp_imm || bus.imm_fmt !== exp_fmt) begin
          errors++;
          $display("FAIL random[%0d] inst=%h: got %h/%0d expected %h/%0d",
                   i, w, bus.inst_out, bus.imm_fmt, exp_imm, exp_fmt);
        end
      end
      r  = $urandom();
      op = (($urandom_range(0, 12) < 10)) ? ops[$urandom_range(0, 9)] : r[6:0];
      w  = {r[31:7], op};
      bus.inst_in = w;
      // Outputs must not follow the input between clock edges.
      if (have_prev) begin
        #1;
        checks++;
        if (bus.inst_out !== exp_imm || bus.imm_fmt !== exp_fmt) begin
          errors++;
          $display("FAIL hold[%0d]: got %h/%0d expected %h/%0d",
                   i, bus.inst_out, bus.imm_fmt, exp_imm, exp_fmt);
        end
      end
      ref_model(w, exp_imm, exp_fmt);
      have_prev = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bus.inst_out !== exp_imm || bus.imm_fmt !== exp_fmt) begin
      errors++;
      $display("FAIL random_last: got %h/%0d expected %h/%0d",
               bus.inst_out, bus.imm_fmt, exp_imm, exp_fmt);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] exp_imm;
    logic [2:0]  exp_fmt;
    @(negedge clk);
    bus.inst_in = 32'h800000B7;
    @(negedge clk);
    checks++;
    if (bus.inst_out !== 64'hFFFFFFFF80000000 || bus.imm_fmt !== FMT_U) begin
      errors++;
      $display("FAIL pre_reset: got %h/%0d expected %h/4",
               bus.inst_out, bus.imm_fmt, 64'hFFFFFFFF80000000);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.inst_out !== 64'h0 || bus.imm_fmt !== FMT_NONE) begin
      errors++;
      $display("FAIL async_reset: got %h/%0d expected 0/0",
               bus.inst_out, bus.imm_fmt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.inst_out !== 64'h0 || bus.imm_fmt !== FMT_NONE) begin
      errors++;
      $display("FAIL reset_held: got %h/%0d expected 0/0",
               bus.inst_out, bus.imm_fmt);
    end
    @(negedge clk);
    reset       = 1'b1;
    bus.inst_in = 32'h8000006F;
    ref_model(32'h8000006F, exp_imm, exp_fmt);
    @(negedge clk);
    checks++;
    if (bus.inst_out !== exp_imm || bus.imm_fmt !== exp_fmt) begin
      errors++;
      $display("FAIL post_reset: got %h/%0d expected %h/%0d",
               bus.inst_out, bus.imm_fmt, exp_imm, exp_fmt);
    end
  endtask

  initial begin
    reset       = 1'b0;
    bus.inst_in = '0;
    test_reset();
    test_directed();
    test_back_to_back_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
